// File: rtl/ariane_soc_decerr_slave_pkg.sv
// Shared widths, AXI channel payloads and error-log helpers for the SoC
// default-port decode-error slave.
package ariane_soc_decerr_slave_pkg;

    localparam int unsigned IdWidthSlave = 5;
    localparam int unsigned AddrWidth    = 64;
    localparam int unsigned DataWidth    = 64;
    localparam int unsigned StrbWidth    = DataWidth / 8;
    localparam int unsigned UserWidth    = 1;
    localparam int unsigned LenWidth     = 8;
    localparam int unsigned ErrCntWidth  = 16;
    localparam int unsigned CntSumWidth  = ErrCntWidth + 1;

    localparam logic [DataWidth-1:0] DecErrData  = 64'hBADC_AB1E_BADC_AB1E;
    localparam logic [1:0]           RESP_DECERR = 2'b11;

    typedef logic [IdWidthSlave-1:0] id_slv_t;
    typedef logic [AddrWidth-1:0]    addr_t;
    typedef logic [LenWidth-1:0]     len_t;

    typedef struct packed {
        id_slv_t              id;
        addr_t                addr;
        len_t                 len;
        logic [2:0]           size;
        logic [1:0]           burst;
        logic                 lock;
        logic [3:0]           cache;
        logic [2:0]           prot;
        logic [3:0]           qos;
        logic [3:0]           region;
        logic [5:0]           atop;
        logic [UserWidth-1:0] user;
    } aw_chan_t;

    typedef struct packed {
        logic [DataWidth-1:0] data;
        logic [StrbWidth-1:0] strb;
        logic                 last;
        logic [UserWidth-1:0] user;
    } w_chan_t;

    typedef struct packed {
        id_slv_t              id;
        logic [1:0]           resp;
        logic [UserWidth-1:0] user;
    } b_chan_t;

    typedef struct packed {
        id_slv_t              id;
        addr_t                addr;
        len_t                 len;
        logic [2:0]           size;
        logic [1:0]           burst;
        logic                 lock;
        logic [3:0]           cache;
        logic [2:0]           prot;
        logic [3:0]           qos;
        logic [3:0]           region;
        logic [UserWidth-1:0] user;
    } ar_chan_t;

    typedef struct packed {
        id_slv_t              id;
        logic [DataWidth-1:0] data;
        logic [1:0]           resp;
        logic                 last;
        logic [UserWidth-1:0] user;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } req_slv_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } resp_slv_t;

    // Fault counter add that pins at all-ones instead of wrapping.
    function automatic logic [ErrCntWidth-1:0] sat_add(input logic [ErrCntWidth-1:0] a,
                                                       input logic [1:0]             inc);
        logic [CntSumWidth-1:0] s;
        s = {1'b0, a} + CntSumWidth'(inc);
        return s[ErrCntWidth] ? {ErrCntWidth{1'b1}} : s[ErrCntWidth-1:0];
    endfunction

endpackage

// File: rtl/ariane_soc_decerr_slave.sv
// Terminating AXI slave for unmapped addresses: answers every access with
// DECERR and keeps a small log of the latest fault and a saturating count.
module ariane_soc_decerr_slave
    import ariane_soc_decerr_slave_pkg::*;
#(
    parameter type                  req_t    = req_slv_t,
    parameter type                  resp_t   = resp_slv_t,
    parameter logic [DataWidth-1:0] RespData = DecErrData
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  req_t                   axi_req_i,
    output resp_t                  axi_resp_o,
    input  logic                   err_clr_i,
    output logic                   err_valid_o,
    output logic [AddrWidth-1:0]   err_addr_o,
    output logic                   err_is_write_o,
    output logic [ErrCntWidth-1:0] err_count_o
);

    // One-hot encodings so each ready/valid is a flop output directly.
    localparam logic [2:0] W_IDLE = 3'b001;
    localparam logic [2:0] W_DATA = 3'b010;
    localparam logic [2:0] W_RESP = 3'b100;
    localparam logic [1:0] R_IDLE = 2'b01;
    localparam logic [1:0] R_DATA = 2'b10;

    logic [2:0]             w_state_q, w_state_d;
    logic [1:0]             r_state_q, r_state_d;
    id_slv_t                b_id_q, b_id_d;
    id_slv_t                r_id_q, r_id_d;
    len_t                   len_q, len_d;
    len_t                   beat_q, beat_d;
    logic                   r_last_q, r_last_d;

    logic                   err_valid_q, err_valid_d;
    addr_t                  err_addr_q, err_addr_d;
    logic                   err_is_write_q, err_is_write_d;
    logic [ErrCntWidth-1:0] err_count_q, err_count_d;

    logic                   aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic [1:0]             n_faults;
    logic                   req_unused;

    assign aw_hs    = axi_req_i.aw_valid & w_state_q[0];
    assign w_hs     = axi_req_i.w_valid  & w_state_q[1];
    assign b_hs     = axi_req_i.b_ready  & w_state_q[2];
    assign ar_hs    = axi_req_i.ar_valid & r_state_q[0];
    assign r_hs     = axi_req_i.r_ready  & r_state_q[1];
    assign n_faults = {1'b0, aw_hs} + {1'b0, ar_hs};

    // Payload fields (data, strobes, burst attributes, atop) are intentionally ignored.
    assign req_unused = ^axi_req_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            w_state_q      <= W_IDLE;
            r_state_q      <= R_IDLE;
            b_id_q         <= '0;
            r_id_q         <= '0;
            len_q          <= '0;
            beat_q         <= '0;
            r_last_q       <= 1'b0;
            err_valid_q    <= 1'b0;
            err_addr_q     <= '0;
            err_is_write_q <= 1'b0;
            err_count_q    <= '0;
        end else begin
            w_state_q      <= w_state_d;
            r_state_q      <= r_state_d;
            b_id_q         <= b_id_d;
            r_id_q         <= r_id_d;
            len_q          <= len_d;
            beat_q         <= beat_d;
            r_last_q       <= r_last_d;
            err_valid_q    <= err_valid_d;
            err_addr_q     <= err_addr_d;
            err_is_write_q <= err_is_write_d;
            err_count_q    <= err_count_d;
        end
    end

    // Write path: accept AW, swallow W beats up to last, return one B.
    always_comb begin
        w_state_d = w_state_q;
        b_id_d    = b_id_q;
        unique case (w_state_q)
            W_IDLE: begin
                if (aw_hs) begin
                    w_state_d = W_DATA;
                    b_id_d    = axi_req_i.aw.id;
                end
            end
            W_DATA: begin
                if (w_hs && axi_req_i.w.last) begin
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (b_hs) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Read path: last is precomputed so r.last is also a plain flop.
    always_comb begin
        r_state_d = r_state_q;
        r_id_d    = r_id_q;
        len_d     = len_q;
        beat_d    = beat_q;
        r_last_d  = r_last_q;
        unique case (r_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    r_state_d = R_DATA;
                    r_id_d    = axi_req_i.ar.id;
                    len_d     = axi_req_i.ar.len;
                    beat_d    = '0;
                    r_last_d  = (axi_req_i.ar.len == LenWidth'(0));
                end
            end
            R_DATA: begin
                if (r_hs) begin
                    if (r_last_q) begin
                        r_state_d = R_IDLE;
                    end else begin
                        beat_d   = beat_q + LenWidth'(1);
                        r_last_d = ((beat_q + LenWidth'(1)) == len_q);
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Error log: a fault in the clear cycle overrides the clear.
    always_comb begin
        err_valid_d    = err_valid_q;
        err_addr_d     = err_addr_q;
        err_is_write_d = err_is_write_q;
        err_count_d    = err_count_q;
        if (err_clr_i) begin
            err_valid_d    = 1'b0;
            err_addr_d     = '0;
            err_is_write_d = 1'b0;
        end
        if (aw_hs || ar_hs) begin
            err_valid_d    = 1'b1;
            err_addr_d     = aw_hs ? axi_req_i.aw.addr : axi_req_i.ar.addr;
            err_is_write_d = aw_hs;
        end
        if (err_clr_i || aw_hs || ar_hs) begin
            err_count_d = sat_add(err_clr_i ? {ErrCntWidth{1'b0}} : err_count_q, n_faults);
        end
    end

    always_comb begin
        axi_resp_o          = '0;
        axi_resp_o.aw_ready = w_state_q[0];
        axi_resp_o.w_ready  = w_state_q[1];
        axi_resp_o.b_valid  = w_state_q[2];
        axi_resp_o.b.id     = b_id_q;
        axi_resp_o.b.resp   = RESP_DECERR;
        axi_resp_o.ar_ready = r_state_q[0];
        axi_resp_o.r_valid  = r_state_q[1];
        axi_resp_o.r.id     = r_id_q;
        axi_resp_o.r.data   = RespData;
        axi_resp_o.r.resp   = RESP_DECERR;
        axi_resp_o.r.last   = r_last_q;
    end

    assign err_valid_o    = err_valid_q;
    assign err_addr_o     = err_addr_q;
    assign err_is_write_o = err_is_write_q;
    assign err_count_o    = err_count_q;

endmodule

// File: tb/tb_ariane_soc_decerr_slave.sv
// Directed bench for the decode-error slave: a transaction-level model is
// compared against the DUT every cycle, plus literal checkpoints.
module tb_ariane_soc_decerr_slave;
    import ariane_soc_decerr_slave_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    req_slv_t    req;
    resp_slv_t   resp;
    logic        err_clr;
    logic        err_valid;
    addr_t       err_addr;
    logic        err_is_write;
    logic [15:0] err_count;

    int n_tests = 0;
    int n_fail  = 0;
    int chk_pt  = 0;
    logic preload_req = 1'b0;

    always #5 clk = ~clk;

    ariane_soc_decerr_slave dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .axi_req_i      (req),
        .axi_resp_o     (resp),
        .err_clr_i      (err_clr),
        .err_valid_o    (err_valid),
        .err_addr_o     (err_addr),
        .err_is_write_o (err_is_write),
        .err_count_o    (err_count)
    );

    // Transaction-level model: outstanding write/read and the fault log.
    logic    m_wr_pend, m_wr_done, m_rd_pend, m_forced;
    id_slv_t m_wr_id, m_rd_id;
    int      m_rd_len, m_rd_sent;
    logic    m_valid, m_isw;
    addr_t   m_addr;
    int      m_cnt;
    int      beat_cnt, n_last, last_idx;

    logic e_aw_h, e_w_h, e_b_h, e_ar_h, e_r_h;
    int   nf, cbase;

    always_comb begin
        e_aw_h = req.aw_valid && !m_wr_pend;
        e_w_h  = req.w_valid && m_wr_pend && !m_wr_done;
        e_b_h  = req.b_ready && m_wr_done;
        e_ar_h = req.ar_valid && !m_rd_pend;
        e_r_h  = req.r_ready && m_rd_pend;
        nf     = int'(e_aw_h) + int'(e_ar_h);
        cbase  = err_clr ? 0 : m_cnt;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_wr_pend <= 1'b0; m_wr_done <= 1'b0; m_wr_id <= '0;
            m_rd_pend <= 1'b0; m_rd_id <= '0; m_rd_len <= 0; m_rd_sent <= 0;
            m_valid <= 1'b0; m_isw <= 1'b0; m_addr <= '0; m_cnt <= 0;
            beat_cnt <= 0; n_last <= 0; last_idx <= 0; m_forced <= 1'b0;
        end else begin
            if (e_b_h) begin
                m_wr_pend <= 1'b0;
                m_wr_done <= 1'b0;
            end else if (e_w_h && req.w.last) begin
                m_wr_done <= 1'b1;
            end else if (e_aw_h) begin
                m_wr_pend <= 1'b1;
                m_wr_id   <= req.aw.id;
            end
            if (e_r_h) begin
                if (m_rd_sent == m_rd_len) m_rd_pend <= 1'b0;
                else                       m_rd_sent <= m_rd_sent + 1;
                beat_cnt <= beat_cnt + 1;
                if (resp.r.last) begin
                    n_last   <= n_last + 1;
                    last_idx <= beat_cnt + 1;
                end
            end else if (e_ar_h) begin
                m_rd_pend <= 1'b1; m_rd_id <= req.ar.id;
                m_rd_len  <= int'(req.ar.len); m_rd_sent <= 0;
                beat_cnt  <= 0; n_last <= 0; last_idx <= 0;
            end
            if (err_clr) begin
                m_valid <= 1'b0; m_addr <= '0; m_isw <= 1'b0;
            end
            if (nf > 0) begin
                m_valid <= 1'b1;
                m_addr  <= e_aw_h ? req.aw.addr : req.ar.addr;
                m_isw   <= e_aw_h;
            end
            if (err_clr || nf > 0) m_cnt <= (cbase + nf > 65535) ? 65535 : cbase + nf;
            if (m_forced) begin
                release dut.err_count_q;
                m_forced <= 1'b0;
            end
            // Reaching the saturation boundary by traffic alone is too slow; preload it.
            if (preload_req) begin
                force dut.err_count_q = 16'hFFFE;
                m_cnt    <= 32'hFFFE;
                m_forced <= 1'b1;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Per-cycle comparison against the model, plus literal checkpoints.
    always @(negedge clk) begin
        chk("aw_ready", 64'(resp.aw_ready), 64'(!m_wr_pend));
        chk("w_ready",  64'(resp.w_ready),  64'(m_wr_pend && !m_wr_done));
        chk("b_valid",  64'(resp.b_valid),  64'(m_wr_done));
        chk("ar_ready", 64'(resp.ar_ready), 64'(!m_rd_pend));
        chk("r_valid",  64'(resp.r_valid),  64'(m_rd_pend));
        if (m_wr_done) begin
            chk("b_id",   64'(resp.b.id),   64'(m_wr_id));
            chk("b_resp", 64'(resp.b.resp), 64'(2'b11));
        end
        if (m_rd_pend) begin
            chk("r_id",   64'(resp.r.id),   64'(m_rd_id));
            chk("r_data", resp.r.data,      64'hBADC_AB1E_BADC_AB1E);
            chk("r_resp", 64'(resp.r.resp), 64'(2'b11));
            chk("r_last", 64'(resp.r.last), 64'(m_rd_sent == m_rd_len));
        end
        chk("err_valid", 64'(err_valid),    64'(m_valid));
        chk("err_addr",  err_addr,          m_addr);
        chk("err_isw",   64'(err_is_write), 64'(m_isw));
        chk("err_count", 64'(err_count),    64'(m_cnt));
        case (chk_pt)
            1: begin
                chk("wr_b_at_c2",  64'(resp.b_valid),  64'd1);
                chk("wr_b_id3",    64'(resp.b.id),     64'd3);
                chk("wr_b_decerr", 64'(resp.b.resp),   64'd3);
                chk("wr_log_addr", err_addr,           64'h5000_0000);
                chk("wr_log_isw",  64'(err_is_write),  64'd1);
                chk("wr_log_cnt",  64'(err_count),     64'd1);
            end
            2: begin
                chk("rd4_beats",    64'(beat_cnt),      64'd4);
                chk("rd4_last_idx", 64'(last_idx),      64'd4);
                chk("rd4_n_last",   64'(n_last),        64'd1);
                chk("rd4_ar_ready", 64'(resp.ar_ready), 64'd1);
            end
            3: begin
                chk("rd256_beats",    64'(beat_cnt),      64'd256);
                chk("rd256_last_idx", 64'(last_idx),      64'd256);
                chk("rd256_n_last",   64'(n_last),        64'd1);
                chk("rd256_ar_ready", 64'(resp.ar_ready), 64'd1);
            end
            4: begin
                chk("early_w_b_valid", 64'(resp.b_valid), 64'd1);
                chk("early_w_b_id",    64'(resp.b.id),    64'd2);
                chk("early_w_addr",    err_addr,          64'h6000_0000);
            end
            5: chk("early_w_stalled", 64'(resp.w_ready), 64'd0);
            6: begin
                chk("sat_count",  64'(err_count),    64'hFFFF);
                chk("sat_addr",   err_addr,          64'h7000_0000);
                chk("sat_isw",    64'(err_is_write), 64'd1);
            end
            7: begin
                chk("clr_hit_count", 64'(err_count),    64'd1);
                chk("clr_hit_isw",   64'(err_is_write), 64'd0);
                chk("clr_hit_addr",  err_addr,          64'h7200_0000);
            end
            8: begin
                chk("clr_valid", 64'(err_valid), 64'd0);
                chk("clr_count", 64'(err_count), 64'd0);
                chk("clr_addr",  err_addr,       64'd0);
            end
            9: begin
                chk("rst_r_valid",  64'(resp.r_valid),  64'd0);
                chk("rst_ar_ready", 64'(resp.ar_ready), 64'd1);
                chk("rst_aw_ready", 64'(resp.aw_ready), 64'd1);
                chk("rst_err_cnt",  64'(err_count),     64'd0);
            end
            10: begin
                chk("post_rst_beats",    64'(beat_cnt), 64'd2);
                chk("post_rst_last_idx", 64'(last_idx), 64'd2);
                chk("post_rst_n_last",   64'(n_last),   64'd1);
            end
            default: ;
        endcase
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        req = '0;
        err_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        cyc();

        // Single write, B expected two cycles after AW.
        req.aw_valid = 1'b1; req.aw.id = 5'd3; req.aw.addr = 64'h5000_0000; req.aw.len = 8'd0;
        cyc();
        req.aw_valid = 1'b0; req.w_valid = 1'b1; req.w.last = 1'b1;
        cyc();
        req.w_valid = 1'b0; req.b_ready = 1'b1; chk_pt = 1;
        cyc();
        req.b_ready = 1'b0; chk_pt = 0;

        // Four-beat read with a stalling r_ready pattern.
        req.ar_valid = 1'b1; req.ar.id = 5'd7; req.ar.addr = 64'h5100_0000; req.ar.len = 8'd3;
        cyc();
        req.ar_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            req.r_ready = (i == 1 || i == 4) ? 1'b0 : 1'b1;
            cyc();
        end
        req.r_ready = 1'b0; chk_pt = 2;
        cyc();
        chk_pt = 0;

        // Maximum-length burst.
        req.ar_valid = 1'b1; req.ar.id = 5'd1; req.ar.addr = 64'h5200_0000; req.ar.len = 8'd255;
        cyc();
        req.ar_valid = 1'b0; req.r_ready = 1'b1;
        repeat (256) cyc();
        req.r_ready = 1'b0; chk_pt = 3;
        cyc();
        chk_pt = 0;

        // W data arriving ahead of AW must stall.
        req.w_valid = 1'b1; req.w.last = 1'b1; chk_pt = 5;
        cyc();
        chk_pt = 0;
        cyc();
        cyc();
        req.aw_valid = 1'b1; req.aw.id = 5'd2; req.aw.addr = 64'h6000_0000;
        cyc();
        req.aw_valid = 1'b0;
        cyc();
        req.w_valid = 1'b0; req.b_ready = 1'b1; chk_pt = 4;
        cyc();
        req.b_ready = 1'b0; chk_pt = 0;

        // Saturation with simultaneous AW and AR, then clear colliding with a fault.
        preload_req = 1'b1;
        cyc();
        preload_req = 1'b0;
        req.aw_valid = 1'b1; req.aw.id = 5'd4; req.aw.addr = 64'h7000_0000;
        req.ar_valid = 1'b1; req.ar.id = 5'd5; req.ar.addr = 64'h7100_0000; req.ar.len = 8'd0;
        cyc();
        req.aw_valid = 1'b0; req.ar_valid = 1'b0;
        req.w_valid = 1'b1; req.r_ready = 1'b1; chk_pt = 6;
        cyc();
        req.w_valid = 1'b0; req.r_ready = 1'b0; req.b_ready = 1'b1; chk_pt = 0;
        req.ar_valid = 1'b1; req.ar.id = 5'd6; req.ar.addr = 64'h7200_0000; err_clr = 1'b1;
        cyc();
        req.ar_valid = 1'b0; err_clr = 1'b0; req.b_ready = 1'b0; req.r_ready = 1'b1; chk_pt = 7;
        cyc();
        req.r_ready = 1'b0; chk_pt = 0; err_clr = 1'b1;
        cyc();
        err_clr = 1'b0; chk_pt = 8;
        cyc();
        chk_pt = 0;

        // Asynchronous reset while the second beat of a burst is on the bus.
        req.ar_valid = 1'b1; req.ar.id = 5'd9; req.ar.addr = 64'h8000_0000; req.ar.len = 8'd5;
        cyc();
        req.ar_valid = 1'b0; req.r_ready = 1'b1;
        cyc();
        #1 rst_n = 1'b0; chk_pt = 9; req.r_ready = 1'b0;
        cyc();
        chk_pt = 0;
        cyc();
        rst_n = 1'b1;
        cyc();
        req.ar_valid = 1'b1; req.ar.id = 5'd10; req.ar.addr = 64'h8100_0000; req.ar.len = 8'd1;
        cyc();
        req.ar_valid = 1'b0; req.r_ready = 1'b1;
        cyc();
        cyc();
        req.r_ready = 1'b0; chk_pt = 10;
        cyc();
        chk_pt = 0;
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
